affine_seq_alu: RTL and testbench
=================================

// Module: affine_seq_alu
// PURPOSE
// - Parametrised multi-cycle affine datapath for the PicoMIPS core: result = (A * imm2) >>> FRAC + B.
// - Generalises the single-width tOP-controlled ALU:
//   - configurable data width and fixed-point shift
//   - iterative radix-2 signed multiplier
//   - optional saturation
//   - dual-width (wdual) product output
//   - sticky halt state
// - Sits between decode (tOP fields, register read data, immediates) and register writeback.
// PARAMETERS
// - N       8  data/immediate width in bits (4..32)
// - FRAC    0  fixed-point fraction bits removed from the product (0..N-1)
// - SAT_EN  1  1 = saturate the final add to signed N-bit range; 0 = two's-complement wrap
// PORTS
// - clk        in   1   rising-edge clock
// - nReset     in   1   asynchronous active-low reset
// - start      in   1   request; accepted only when ready=1
// - ready      out  1   high in IDLE only
// - wdual      in   1   tOP.wdual: drive result_hi with product upper half
// - mul_a_sel  in   2   tOP.mul_a_sel: 00 rs_data, 01 rd_data, 10 imm1, 11 constant +1
// - add_b_sel  in   2   tOP.add_b_sel: 00 zero, 01 rs_data, 10 rd_data, 11 imm1
// - halt       in   1   tOP.halt; sampled with start
// - rs_data    in   N   signed source register value
// - rd_data    in   N   signed destination register value
// - imm1       in   N   signed immediate 1
// - imm2       in   N   signed immediate 2 (multiplier operand B, always)
// - result     out  N   signed affine result
// - result_hi  out  N   product[2N-1:N] when wdual latched, else 0
// - valid      out  1   one-cycle pulse: result/result_hi valid
// - busy       out  1   high in MUL and ADD
// - halted     out  1   high in HALT
// BEHAVIOUR
// - Reset (async, nReset=0):
//   - state=IDLE; result, result_hi, valid, busy, halted = 0; ready = 1 once nReset deasserts.
//   - Reset mid-operation aborts with no valid pulse.
// - States:
//   - IDLE: ready=1.
//     - start & halt -> HALT.
//     - start & !halt -> MUL.
//     - At acceptance, latch all operands and sel fields; later input changes are ignored.
//   - MUL: exactly N cycles, one partial product per cycle.
//     - 2N-bit signed product must be exact for all inputs, incl. (-2^(N-1))*(-2^(N-1)).
//   - ADD: 1 cycle.
//     - scaled = product >>> FRAC (arithmetic, floor), take low N+1 bits.
//     - sum = scaled + B, computed N+2 bits wide.
//     - SAT_EN=1: clamp sum to [-2^(N-1), 2^(N-1)-1].
//     - SAT_EN=0: take low N bits.
//     - Go to DONE.
//   - DONE: 1 cycle.
//     - valid=1; result/result_hi registered; ready=0; start ignored.
//     - Go to IDLE. result and result_hi hold their values until the next DONE.
//   - HALT: sticky; ready=0, halted=1; start ignored; exits only via nReset.
// - Latency:
//   - start accepted at edge E0; valid is high in the cycle after edge E0+N+2.
//   - Throughput is one operation per N+3 cycles.
// - start while ready=0 is dropped, not queued.
// - mul_a_sel=11: A=+1, so result = (imm2 >>> FRAC) + B.
// TESTING
// Unless stated, N=8, FRAC=0, SAT_EN=1.
// - Basic: rs=5, imm2=3, sel_a=00, sel_b=11, imm1=7 -> result=0x16, valid 10 cycles after accept, result_hi=0.
// - Signed/wdual: rs=0xFC, imm2=0x03, wdual=1, sel_b=00 -> result=0xF4, result_hi=0xFF.
// - Extreme: rs=0x80, imm2=0x80, wdual=1, sel_b=00 -> result=0x00, result_hi=0x40.
// - Saturation: rs=0x7F, imm2=0x01, sel_b=10, rd=0x01 -> 0x7F with SAT_EN=1; 0x80 with SAT_EN=0.
// - Fixed point (FRAC=4): rs=0x18, imm2=0x20, sel_b=00 -> 0x30; rs=0xE8, imm2=0x20 -> 0xD0.
// - Control:
//   - start with halt=1 -> halted=1, ready=0; further starts give no valid; nReset pulse -> ready=1.
//   - nReset low during MUL cycle 4 -> no valid, all outputs 0.
//   - start during busy -> ignored.

Source files
------------

// File: rtl/affine_seq_alu.sv
// affine_seq_alu: multi-cycle affine datapath, result = (A * imm2) >>> FRAC + B.
// An iterative radix-2 signed multiplier produces an exact 2N-bit product.
// One add cycle follows, with optional saturation. A sticky halt state is
// left only through nReset.
module affine_seq_alu #(
  parameter int N      = 8,
  parameter int FRAC   = 0,
  parameter bit SAT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  output logic         ready,
  input  logic         wdual,
  input  logic [1:0]   mul_a_sel,
  input  logic [1:0]   add_b_sel,
  input  logic         halt,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rd_data,
  input  logic [N-1:0] imm1,
  input  logic [N-1:0] imm2,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         valid,
  output logic         busy,
  output logic         halted
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_DONE = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          state_q;
  logic [2*N-1:0]  mcand_q;     // sign-extended A, shifted left each MUL cycle
  logic [N-1:0]    mplier_q;    // imm2, shifted right each MUL cycle
  logic [2*N-1:0]  prod_q;
  logic [CW-1:0]   count_q;
  logic [N-1:0]    b_q;
  logic            wdual_q;
  logic [N-1:0]    sum_q;
  logic [N-1:0]    result_q;
  logic [N-1:0]    result_hi_q;
  logic            valid_q;

  logic [N-1:0]    a_mux_s;
  logic [N-1:0]    b_mux_s;
  logic [2*N-1:0]  addend_s;
  logic [2*N-1:0]  prod_d;
  logic [N:0]      scaled_s;
  logic [N+1:0]    sum_s;
  logic [2:0]      sum_top_s;
  logic [N-1:0]    sat_s;

  // Operand selection, partial-product step and final scaled add/saturate
  always_comb begin
    a_mux_s   = rs_data;
    b_mux_s   = {N{1'b0}};
    addend_s  = {(2*N){1'b0}};
    prod_d    = prod_q;
    scaled_s  = {(N+1){1'b0}};
    sum_s     = {(N+2){1'b0}};
    sum_top_s = 3'b000;
    sat_s     = {N{1'b0}};

    case (mul_a_sel)
      2'b00:   a_mux_s = rs_data;
      2'b01:   a_mux_s = rd_data;
      2'b10:   a_mux_s = imm1;
      2'b11:   a_mux_s = {{(N-1){1'b0}}, 1'b1};
      default: a_mux_s = rs_data;
    endcase

    case (add_b_sel)
      2'b00:   b_mux_s = {N{1'b0}};
      2'b01:   b_mux_s = rs_data;
      2'b10:   b_mux_s = rd_data;
      2'b11:   b_mux_s = imm1;
      default: b_mux_s = {N{1'b0}};
    endcase

    // The multiplier's MSB carries weight -2^(N-1), so the last step subtracts.
    if (mplier_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
    if (count_q == CW'(N-1)) begin
      prod_d = prod_q - addend_s;
    end else begin
      prod_d = prod_q + addend_s;
    end

    // Arithmetic shift by FRAC keeping N+1 bits; FRAC+N never exceeds 2N-1.
    scaled_s  = prod_q[FRAC +: N+1];
    sum_s     = {scaled_s[N], scaled_s} + {{2{b_q[N-1]}}, b_q};
    sum_top_s = sum_s[N+1:N-1];

    if (SAT_EN && (sum_top_s != 3'b000) && (sum_top_s != 3'b111)) begin
      if (sum_s[N+1]) begin
        sat_s = {1'b1, {(N-1){1'b0}}};
      end else begin
        sat_s = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      sat_s = sum_s[N-1:0];
    end
  end

  // Control FSM with operand latches, datapath registers and registered outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      mcand_q     <= {(2*N){1'b0}};
      mplier_q    <= {N{1'b0}};
      prod_q      <= {(2*N){1'b0}};
      count_q     <= {CW{1'b0}};
      b_q         <= {N{1'b0}};
      wdual_q     <= 1'b0;
      sum_q       <= {N{1'b0}};
      result_q    <= {N{1'b0}};
      result_hi_q <= {N{1'b0}};
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (halt) begin
              state_q <= S_HALT;
            end else begin
              mcand_q  <= {{N{a_mux_s[N-1]}}, a_mux_s};
              mplier_q <= imm2;
              prod_q   <= {(2*N){1'b0}};
              count_q  <= {CW{1'b0}};
              b_q      <= b_mux_s;
              wdual_q  <= wdual;
              state_q  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[2*N-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[N-1:1]};
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(N-1)) begin
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q   <= sat_s;
          state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= sum_q;
          if (wdual_q) begin
            result_hi_q <= prod_q[2*N-1:N];
          end else begin
            result_hi_q <= {N{1'b0}};
          end
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL) || (state_q == S_ADD);
  assign halted    = (state_q == S_HALT);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_affine_seq_alu.sv
// Scoreboard bench for affine_seq_alu. Three instances share the same stimulus:
// the default (FRAC=0, SAT_EN=1), a wrapping one (SAT_EN=0) and a fixed-point
// one (FRAC=4). Each instance has its own expected-result queue.
module tb_affine_seq_alu;

  localparam int N   = 8;
  localparam int LAT = N + 2;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic       wdual = 1'b0;
  logic [1:0] mul_a_sel = 2'b00;
  logic [1:0] add_b_sel = 2'b00;
  logic       halt = 1'b0;
  logic [7:0] rs_data = 8'h00;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] imm1 = 8'h00;
  logic [7:0] imm2 = 8'h00;

  logic       rdy0, rdy1, rdy2, v0, v1, v2, b0, b1, b2, hl0, hl1, hl2;
  logic [7:0] r0, r1, r2, h0, h1, h2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] hi;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  affine_seq_alu #(.N(8), .FRAC(0), .SAT_EN(1'b1)) u_dut (
    .clk(clk), .nReset(nReset), .start(start), .ready(rdy0), .wdual(wdual),
    .mul_a_sel(mul_a_sel), .add_b_sel(add_b_sel), .halt(halt),
    .rs_data(rs_data), .rd_data(rd_data), .imm1(imm1), .imm2(imm2),
    .result(r0), .result_hi(h0), .valid(v0), .busy(b0), .halted(hl0));

  affine_seq_alu #(.N(8), .FRAC(0), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .nReset(nReset), .start(start), .ready(rdy1), .wdual(wdual),
    .mul_a_sel(mul_a_sel), .add_b_sel(add_b_sel), .halt(halt),
    .rs_data(rs_data), .rd_data(rd_data), .imm1(imm1), .imm2(imm2),
    .result(r1), .result_hi(h1), .valid(v1), .busy(b1), .halted(hl1));

  affine_seq_alu #(.N(8), .FRAC(4), .SAT_EN(1'b1)) u_frac (
    .clk(clk), .nReset(nReset), .start(start), .ready(rdy2), .wdual(wdual),
    .mul_a_sel(mul_a_sel), .add_b_sel(add_b_sel), .halt(halt),
    .rs_data(rs_data), .rd_data(rd_data), .imm1(imm1), .imm2(imm2),
    .result(r2), .result_hi(h2), .valid(v2), .busy(b2), .halted(hl2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the selected operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                                input bit wd, input int frac, input bit sat,
                                output logic [7:0] r, output logic [7:0] hi);
    longint prod, sc, sum;
    logic [8:0] low9;
    logic [63:0] pbits;
    prod  = longint'($signed(a)) * longint'($signed(m));
    sc    = prod >>> frac;
    low9  = sc[8:0];
    sum   = longint'($signed(low9)) + longint'($signed(b));
    if (sat && sum > 127)  sum = 127;
    if (sat && sum < -128) sum = -128;
    r     = sum[7:0];
    pbits = prod;
    hi    = wd ? pbits[15:8] : 8'h00;
  endfunction

  // Drive one cycle of inputs; if the DUT is ready and this is a real op, predict it.
  task automatic drive(input bit st, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [7:0] rs, input logic [7:0] rd, input logic [7:0] i1,
                       input logic [7:0] i2, input bit wd, input bit hl);
    logic [7:0] a, b;
    exp_t e;
    start = st; mul_a_sel = sa; add_b_sel = sb; rs_data = rs; rd_data = rd;
    imm1 = i1; imm2 = i2; wdual = wd; halt = hl;
    if (st && rdy0 && !hl) begin
      case (sa)
        2'b00: a = rs;
        2'b01: a = rd;
        2'b10: a = i1;
        default: a = 8'h01;
      endcase
      case (sb)
        2'b00: b = 8'h00;
        2'b01: b = rs;
        2'b10: b = rd;
        default: b = i1;
      endcase
      e.cyc = cyc + 1;
      model(a, b, i2, wd, 0, 1'b1, e.r, e.hi); q0.push_back(e);
      model(a, b, i2, wd, 0, 1'b0, e.r, e.hi); q1.push_back(e);
      model(a, b, i2, wd, 4, 1'b1, e.r, e.hi); q2.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] rs,
                       input logic [7:0] rd, input logic [7:0] i1, input logic [7:0] i2,
                       input bit wd);
    drive(1'b1, sa, sb, rs, rd, i1, i2, wd, 1'b0);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    start = 1'b0;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    @(negedge clk);
  endtask

  // Monitor: pop and compare whenever an instance presents valid.
  always @(negedge clk) begin
    exp_t e;
    if (v0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++; $display("FAIL unexpected_valid0: got valid=1 expected 0");
      end else begin
        e = q0.pop_front();
        cmp("res0", r0, e.r); cmp("hi0", h0, e.hi); cmp("lat0", cyc, e.cyc + LAT);
      end
    end
    if (v1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++; $display("FAIL unexpected_valid1: got valid=1 expected 0");
      end else begin
        e = q1.pop_front();
        cmp("res1", r1, e.r); cmp("hi1", h1, e.hi); cmp("lat1", cyc, e.cyc + LAT);
      end
    end
    if (v2) begin
      checks++;
      if (q2.size() == 0) begin
        failures++; $display("FAIL unexpected_valid2: got valid=1 expected 0");
      end else begin
        e = q2.pop_front();
        cmp("res2", r2, e.r); cmp("hi2", h2, e.hi); cmp("lat2", cyc, e.cyc + LAT);
      end
    end
  end

  function automatic logic [7:0] pick();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    cmp("rst_result", r0, 8'h00); cmp("rst_hi", h0, 8'h00); cmp("rst_valid", v0, 1'b0);
    cmp("rst_busy", b0, 1'b0); cmp("rst_halted", hl0, 1'b0);
    nReset = 1'b1;
    @(negedge clk);
    cmp("rst_ready", rdy0, 1'b1);

    // Basic
    issue(2'b00, 2'b11, 8'd5, 8'h00, 8'd7, 8'd3, 1'b0);
    drain();
    cmp("basic_res", r0, 8'h16); cmp("basic_hi", h0, 8'h00);

    // Signed with wdual
    issue(2'b00, 2'b00, 8'hFC, 8'h00, 8'h00, 8'h03, 1'b1);
    drain();
    cmp("signed_res", r0, 8'hF4); cmp("signed_hi", h0, 8'hFF);

    // Extreme negative * negative
    issue(2'b00, 2'b00, 8'h80, 8'h00, 8'h00, 8'h80, 1'b1);
    drain();
    cmp("extreme_res", r0, 8'h00); cmp("extreme_hi", h0, 8'h40);

    // Saturation vs wrap
    issue(2'b00, 2'b10, 8'h7F, 8'h01, 8'h00, 8'h01, 1'b0);
    drain();
    cmp("sat_res", r0, 8'h7F); cmp("wrap_res", r1, 8'h80);

    // Fixed point FRAC=4
    issue(2'b00, 2'b00, 8'h18, 8'h00, 8'h00, 8'h20, 1'b0);
    drain();
    cmp("frac_pos", r2, 8'h30);
    issue(2'b00, 2'b00, 8'hE8, 8'h00, 8'h00, 8'h20, 1'b0);
    drain();
    cmp("frac_neg", r2, 8'hD0);

    // Constant +1 multiplicand
    issue(2'b11, 2'b11, 8'h00, 8'h00, 8'd10, 8'd20, 1'b0);
    drain();
    cmp("one_res", r0, 8'd30);

    // Starts while busy are dropped
    issue(2'b00, 2'b00, 8'd2, 8'h00, 8'h00, 8'd9, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 2'b01, 2'b11, 8'h55, 8'h66, 8'h77, 8'h11, 1'b1, 1'b0);
    drain();
    cmp("busy_drop_res", r0, 8'h12); cmp("busy_drop_hi", h0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 2) == 0), 2'($urandom), 2'($urandom), pick(), pick(),
            pick(), pick(), 1'($urandom), 1'b0);
    end
    drain();

    // Reset during MUL aborts without a valid pulse
    issue(2'b00, 2'b11, 8'h7F, 8'h00, 8'h33, 8'h7F, 1'b1);
    q0.delete(); q1.delete(); q2.delete();
    repeat (3) @(negedge clk);
    cmp("mid_busy", b0, 1'b1);
    nReset = 1'b0;
    #1;
    cmp("mid_rst_res", r0, 8'h00); cmp("mid_rst_hi", h0, 8'h00);
    cmp("mid_rst_valid", v0, 1'b0); cmp("mid_rst_busy", b0, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (15) @(negedge clk);
    cmp("mid_after_res", r0, 8'h00);

    // Sticky halt
    drive(1'b1, 2'b00, 2'b00, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
    start = 1'b0; halt = 1'b0;
    cmp("halt_halted", hl0, 1'b1); cmp("halt_ready", rdy0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b00, 2'b11, 8'd3, 8'd0, 8'd1, 8'd3, 1'b0, 1'b0);
    start = 1'b0;
    cmp("halt_sticky", hl0, 1'b1); cmp("halt_no_ready", rdy0, 1'b0);
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    cmp("unhalt_ready", rdy0, 1'b1); cmp("unhalt_halted", hl0, 1'b0);
    issue(2'b00, 2'b11, 8'd5, 8'h00, 8'd7, 8'd3, 1'b0);
    drain();
    cmp("unhalt_res", r0, 8'h16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
